// File: rtl/pcs_pkg.sv
// Shared constants, alignment-marker tables and BIP helper for the multi-lane TX PCS.
package pcs_pkg;

  localparam int unsigned BLOCK_W   = 66;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned BIP_W     = 8;
  localparam int unsigned AM_M_W    = 24;

  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [1:0] SYNC_DATA = 2'b10;

  localparam logic [PAYLOAD_W-1:0] IDLE_BLOCK = {56'h0, 8'h1E};

  // Self-synchronous scrambler x^58 + x^39 + 1
  localparam int unsigned SCR_W      = 58;
  localparam int unsigned SCR_TAP_LO = 39;
  localparam int unsigned SCR_TAP_HI = 58;
  localparam logic [SCR_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic {
    S_AM   = 1'b0,
    S_XFER = 1'b1
  } tx_state_e;

  // Alignment marker block as it sits on a lane, MSB first
  typedef struct packed {
    logic [7:0] bip7;
    logic [7:0] m2_n;
    logic [7:0] m1_n;
    logic [7:0] m0_n;
    logic [7:0] bip3;
    logic [7:0] m2;
    logic [7:0] m1;
    logic [7:0] m0;
    logic [1:0] sync;
  } am_block_t;

  // Returns {M2,M1,M0} for a lane: 100GBASE-R table for 20 lanes, 40GBASE-R otherwise
  function automatic logic [AM_M_W-1:0] am_m012(input int unsigned lane,
                                                 input int unsigned num_lanes);
    logic [AM_M_W-1:0] m;
    m = '0;
    if (num_lanes == 20) begin
      case (lane)
        0:  m = 24'h21_68_C1;
        1:  m = 24'h8E_71_9D;
        2:  m = 24'hE8_4B_59;
        3:  m = 24'h7B_95_4D;
        4:  m = 24'h09_07_F5;
        5:  m = 24'hC2_14_DD;
        6:  m = 24'h26_4A_9A;
        7:  m = 24'h66_45_7B;
        8:  m = 24'h76_24_A0;
        9:  m = 24'hFB_C9_68;
        10: m = 24'h99_6C_FD;
        11: m = 24'h55_91_B9;
        12: m = 24'hB2_B9_5C;
        13: m = 24'hBD_F8_1A;
        14: m = 24'hCA_C7_83;
        15: m = 24'hCD_36_35;
        16: m = 24'h4C_31_C4;
        17: m = 24'hB7_D6_AD;
        18: m = 24'h2A_66_5F;
        19: m = 24'hE5_F0_C0;
        default: m = '0;
      endcase
    end else begin
      case (lane)
        0: m = 24'h47_76_90;
        1: m = 24'hE6_C4_F0;
        2: m = 24'h9B_65_C5;
        3: m = 24'h3D_79_A2;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // BIP3 contribution of one 66b block: bit k covers k+2, k+10, ..., k+58; sync bits fold into 3 and 4
  function automatic logic [BIP_W-1:0] bip_contrib(input logic [BLOCK_W-1:0] blk);
    logic [BIP_W-1:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        p[k] = p[k] ^ blk[k + 2 + 8*m];
      end
    end
    p[3] = p[3] ^ blk[0];
    p[4] = p[4] ^ blk[1];
    return p;
  endfunction

endpackage

// File: rtl/pcs_bip_accum.sv
// Per-lane BIP3 accumulator; reloads with the marker's own contribution when an AM is sent.
module pcs_bip_accum
  import pcs_pkg::*;
(
  input  logic               core_clk,
  input  logic               core_reset,
  input  logic               accum_en,
  input  logic               load,
  input  logic [BLOCK_W-1:0] blk,
  output logic [BIP_W-1:0]   bip
);

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      bip <= '0;
    end else if (load) begin
      bip <= bip_contrib(blk);
    end else if (accum_en) begin
      bip <= bip ^ bip_contrib(blk);
    end
  end

endmodule

// File: rtl/pcs_tx_am_lane_dist.sv
// Multi-lane TX PCS back end: scrambles 66b columns, inserts per-lane alignment markers
// with BIP3/BIP7 every AM_INTERVAL+1 cycles and fills idle columns when upstream is empty.
module pcs_tx_am_lane_dist
  import pcs_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned AM_INTERVAL = 16383,
  parameter bit          SCRAMBLE_EN = 1'b1
) (
  input  logic                           core_clk,
  input  logic                           core_reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*BLOCK_W-1:0]   in_data,
  output logic                           out_valid,
  output logic                           out_am,
  output logic [NUM_LANES*BLOCK_W-1:0]   out_lane
);

  localparam int unsigned COL_W = NUM_LANES * BLOCK_W;
  localparam int unsigned PL_W  = NUM_LANES * PAYLOAD_W;
  localparam int unsigned EXT_W = PL_W + SCR_W;
  localparam int unsigned CNT_W = $clog2(AM_INTERVAL + 1);

  if (!(NUM_LANES == 4 || NUM_LANES == 20)) begin : g_bad_num_lanes
    $error("pcs_tx_am_lane_dist: NUM_LANES must be 4 or 20");
  end
  if (AM_INTERVAL < 1) begin : g_bad_am_interval
    $error("pcs_tx_am_lane_dist: AM_INTERVAL must be >= 1");
  end

  tx_state_e                    state, state_nxt;
  logic [CNT_W-1:0]             am_cnt, am_cnt_nxt;
  logic [SCR_W-1:0]             scr_state, scr_nxt;
  logic                         scr_upd;
  logic [PL_W-1:0]              pl_raw, pl_scr;
  logic [EXT_W-1:0]             ext;
  logic [COL_W-1:0]             am_col, col;
  logic                         col_am;
  logic [NUM_LANES-1:0][BIP_W-1:0] bip_acc;

  // Alignment marker column built from the lane table and the running BIP
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [AM_M_W-1:0] M012 = am_m012(i, NUM_LANES);

    assign am_col[i*BLOCK_W +: BLOCK_W] = am_block_t'{
      bip7: ~bip_acc[i],
      m2_n: ~M012[23:16],
      m1_n: ~M012[15:8],
      m0_n: ~M012[7:0],
      bip3: bip_acc[i],
      m2:   M012[23:16],
      m1:   M012[15:8],
      m0:   M012[7:0],
      sync: SYNC_CTRL
    };

    pcs_bip_accum u_bip (
      .core_clk   (core_clk),
      .core_reset (core_reset),
      .accum_en   (state == S_XFER),
      .load       (state == S_AM),
      .blk        (col[i*BLOCK_W +: BLOCK_W]),
      .bip        (bip_acc[i])
    );
  end

  // Scrambler unrolled over the column; ext holds the 58 prior output bits followed by this column
  always_comb begin
    pl_raw  = '0;
    ext     = '0;
    scr_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pl_raw[i*PAYLOAD_W +: PAYLOAD_W] = in_valid ? in_data[i*BLOCK_W + 2 +: PAYLOAD_W] : IDLE_BLOCK;
    end
    for (int k = 0; k < SCR_W; k++) begin
      ext[SCR_W - 1 - k] = scr_state[k];
    end
    for (int j = 0; j < PL_W; j++) begin
      ext[SCR_W + j] = pl_raw[j] ^ ext[j + SCR_TAP_HI - SCR_TAP_LO] ^ ext[j];
    end
    for (int k = 0; k < SCR_W; k++) begin
      scr_nxt[k] = ext[EXT_W - 1 - k];
    end
    pl_scr = SCRAMBLE_EN ? ext[EXT_W-1:SCR_W] : pl_raw;
  end

  // Next-state and column select
  always_comb begin
    state_nxt  = state;
    am_cnt_nxt = am_cnt;
    col        = am_col;
    col_am     = 1'b0;
    scr_upd    = 1'b0;
    case (state)
      S_AM: begin
        col        = am_col;
        col_am     = 1'b1;
        am_cnt_nxt = '0;
        state_nxt  = S_XFER;
      end
      S_XFER: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          col[i*BLOCK_W +: BLOCK_W] = {pl_scr[i*PAYLOAD_W +: PAYLOAD_W],
                                       in_valid ? in_data[i*BLOCK_W +: 2] : SYNC_CTRL};
        end
        scr_upd    = 1'b1;
        am_cnt_nxt = am_cnt + CNT_W'(1);
        if (am_cnt == CNT_W'(AM_INTERVAL - 1)) begin
          state_nxt = S_AM;
        end
      end
      default: begin
        state_nxt = S_AM;
      end
    endcase
  end

  // State register
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      state  <= S_AM;
      am_cnt <= '0;
    end else begin
      state  <= state_nxt;
      am_cnt <= am_cnt_nxt;
    end
  end

  // Scrambler state and registered outputs
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      scr_state <= SCR_SEED;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_am    <= 1'b0;
      out_lane  <= '0;
    end else begin
      if (scr_upd) begin
        scr_state <= scr_nxt;
      end
      in_ready  <= (state_nxt == S_XFER);
      out_valid <= 1'b1;
      out_am    <= col_am;
      out_lane  <= col;
    end
  end

endmodule
